ramexp_cycle_ctrl: RTL
======================

Name: ramexp_cycle_ctrl

Overview:
Synchronous sequencer for the CPC 512K expansion RAM card; sits between the Z80 bus pins and the bank-mapping decode logic.
- Captures bank-select writes to port &7Fxx.
- Defers each new configuration until no memory cycle is in flight, so the bank never changes mid-access.
- Tracks memory read/write cycles with a write-cycle FSM that honours READY wait states.
- Latches A15 per cycle and aborts runaway wait states with a sticky error flag.

Parameters:
WAIT_MAX, 15, max consecutive clk cycles in T1 with READY low before abort (1..255)
CFG_RESET, 6'b000000, value loaded into active and pending config at reset (bank 0, scheme 0)
WCNT_W, 8, width of wait-state counter; must hold WAIT_MAX

Ports:
clk  in  1  CPC 4 MHz clock; all state updates on posedge
reset_b  in  1  asynchronous active-low reset
mreq_b  in  1  Z80 MREQ*
iorq_b  in  1  Z80 IORQ*
rfsh_b  in  1  Z80 RFSH*
rd_b  in  1  Z80 RD* (sensed input only)
wr_b  in  1  Z80 WR*
adr15  in  1  Z80 A15 (sensed input only)
ready  in  1  CPC READY/WAIT, high = no wait
data  in  8  Z80 data bus
cfg  out  6  active config {ccc,bbb} to the bank mapper
cfg_pending  out  1  new config captured, not yet applied
mwr_cyc  out  1  expansion write cycle in progress (FSM in T1 or T2)
mrd_cyc  out  1  memory read cycle: !mreq_b & rfsh_b & !rd_b, registered
adr15_lat  out  1  A15 captured at the first clk of the current memory cycle
wait_err  out  1  sticky: a write cycle was aborted by the wait watchdog
err_clr  in  1  synchronous clear of wait_err

Behaviour:
Reset (reset_b low, async):
- cfg = pending = CFG_RESET; cfg_pending = 0; state = IDLE; mrd_cyc = 0; adr15_lat = 0; wait_err = 0; wait counter = 0; ready_q = 1; io_seen = 0.

I/O capture:
- iowr_hit = !iorq_b & !wr_b & !adr15 & data[7:6]==2'b11.
- On the first posedge with iowr_hit and io_seen = 0: pending <= data[5:0]; cfg_pending <= 1; io_seen <= 1.
- io_seen clears on any posedge with iorq_b high, giving exactly one capture per I/O cycle.
- A second write before apply overwrites pending (last write wins).

Apply:
- Condition: cfg_pending & state in {IDLE, END} & mreq_b high.
- Action: cfg <= pending; cfg_pending <= 0.
- If a capture and an apply coincide, the capture wins: pending <= new data, cfg_pending stays 1, and cfg is not updated that cycle.

Write FSM (encoding IDLE=00, T1=01, T2=11, END=10):
- IDLE/END -> T1 when !mreq_b & rfsh_b & rd_b; otherwise -> IDLE. The same condition in END starts a back-to-back write.
- T1 -> T2 when ready_q = 1. ready_q is ready registered on posedge, giving one cycle of latency.
- T1 -> IDLE when wait count reaches WAIT_MAX with ready_q low: set wait_err, reset the counter.
- T2 -> END unconditionally.
- Wait counter increments in T1 while ready_q = 0; clears on any other state or when ready_q = 1.
- mwr_cyc = (state == T1) | (state == T2), decoded combinationally from state.

adr15_lat:
- Loads adr15 on the posedge where mreq_b is low and the previous sampled mreq_b was high.
- Holds until the next such edge.

mrd_cyc:
- Registered each posedge; 0 during refresh (rfsh_b low).

wait_err:
- Clears when err_clr = 1, unless a set occurs on the same cycle; set has priority.

Reset mid-cycle: all state returns to reset values immediately; the in-flight cycle is not completed.

Decomposition:
- Package ramexp_pkg holds: state encodings (IDLE/T1/T2/END), IO_SEL_MASK 2'b11, config field positions (ccc = [5:3], bbb = [2:0]), and the CFG_RESET default.
- One sub-module, ramexp_cfg_reg: I/O capture, io_seen, pending register and apply handshake.
- The FSM, watchdog and latches stay at top level.

Test Plan:
- Reset, then IOWR of data 0xC2 with adr15 = 0 while idle -> cfg_pending = 1 next posedge; cfg = 6'b000010 on the following posedge; cfg_pending = 0.
- IOWR of 0xCA issued while a write cycle holds the FSM in T1 -> cfg stays old through T1/T2; updates to 6'b001010 on the first posedge in END/IDLE with mreq_b high.
- Memory write with ready low for 3 clks -> state sequence IDLE,T1,T1,T1,T1,T2,END,IDLE; mwr_cyc high exactly 5 cycles; wait_err = 0.
- ready held low for 20 clks with WAIT_MAX = 15 -> FSM returns to IDLE after 15 wait cycles; wait_err = 1 and stays set until err_clr pulses.
- IOWR with data 0x82 (bit 6 = 0), and separately with adr15 = 1 -> no capture, cfg_pending stays 0; a refresh cycle (rfsh_b low) -> mwr_cyc = 0 and mrd_cyc = 0.
- reset_b asserted while in T2 with cfg_pending = 1 -> all outputs return to reset values asynchronously; cfg = CFG_RESET.

Source files
------------

// File: rtl/ramexp_pkg.sv
// ramexp_pkg: shared types and constants for the CPC 512K expansion RAM
// cycle controller.
//   wr_state_e        : write-cycle FSM encoding (IDLE=00, T1=01, T2=11, END=10)
//   cfg_t             : bank-select config, ccc in [5:3], bbb in [2:0]
//   IO_SEL_MASK       : data[7:6] pattern that marks a bank-select I/O write
//   CFG_RESET_DEFAULT : config after reset (bank 0, scheme 0)
package ramexp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_T1   = 2'b01,
    ST_T2   = 2'b11,
    ST_END  = 2'b10
  } wr_state_e;

  typedef struct packed {
    logic [2:0] ccc;
    logic [2:0] bbb;
  } cfg_t;

  localparam logic [1:0] IO_SEL_MASK       = 2'b11;
  localparam cfg_t       CFG_RESET_DEFAULT = '{ccc: 3'b000, bbb: 3'b000};

endpackage

// File: rtl/ramexp_cfg_reg.sv
// ramexp_cfg_reg: captures bank-select writes to port &7Fxx into a pending
// register and hands them to the active config only when the top level says
// no memory cycle is in flight.
//   i_iorq_b, i_wr_b, i_adr15, i_data : Z80 bus sense
//   i_apply_ok    : write FSM idle/ending and MREQ* high
//   o_cfg         : active config {ccc,bbb}
//   o_cfg_pending : a captured config is waiting to be applied
module ramexp_cfg_reg
  import ramexp_pkg::*;
#(
  parameter cfg_t CFG_RESET = CFG_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       i_iorq_b,
  input  logic       i_wr_b,
  input  logic       i_adr15,
  input  logic [7:0] i_data,
  input  logic       i_apply_ok,
  output logic [5:0] o_cfg,
  output logic       o_cfg_pending
);

  logic w_iowr_hit;
  logic w_capture;
  cfg_t r_cfg;
  cfg_t r_pending;
  logic r_cfg_pending;
  logic r_io_seen;

  assign w_iowr_hit = !i_iorq_b && !i_wr_b && !i_adr15 && (i_data[7:6] == IO_SEL_MASK);
  // An I/O write spans several clocks; only its first clock captures.
  assign w_capture  = w_iowr_hit && !r_io_seen;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cfg         <= CFG_RESET;
      r_pending     <= CFG_RESET;
      r_cfg_pending <= 1'b0;
      r_io_seen     <= 1'b0;
    end else begin
      if (i_iorq_b) begin
        r_io_seen <= 1'b0;
      end else if (w_capture) begin
        r_io_seen <= 1'b1;
      end
      // A fresh capture beats a coincident apply: the newer value must not be
      // lost, so the active config waits one more opportunity.
      if (w_capture) begin
        r_pending     <= cfg_t'(i_data[5:0]);
        r_cfg_pending <= 1'b1;
      end else if (r_cfg_pending && i_apply_ok) begin
        r_cfg         <= r_pending;
        r_cfg_pending <= 1'b0;
      end
    end
  end

  assign o_cfg         = r_cfg;
  assign o_cfg_pending = r_cfg_pending;

endmodule

// File: rtl/ramexp_cycle_ctrl.sv
// ramexp_cycle_ctrl: Z80 bus sequencer for the CPC 512K expansion RAM card.
// Tracks memory write cycles (honouring READY waits, with a watchdog),
// registers read-cycle and A15 status, and defers bank config changes until
// no memory cycle is in flight.
//   Inputs : mreq_b, iorq_b, rfsh_b, rd_b, wr_b, adr15, ready, data[7:0], err_clr
//   Outputs: cfg[5:0], cfg_pending, mwr_cyc, mrd_cyc, adr15_lat, wait_err
module ramexp_cycle_ctrl
  import ramexp_pkg::*;
#(
  parameter int unsigned WAIT_MAX  = 15,
  parameter logic [5:0]  CFG_RESET = CFG_RESET_DEFAULT,
  parameter int unsigned WCNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       mreq_b,
  input  logic       iorq_b,
  input  logic       rfsh_b,
  input  logic       rd_b,
  input  logic       wr_b,
  input  logic       adr15,
  input  logic       ready,
  input  logic [7:0] data,
  output logic [5:0] cfg,
  output logic       cfg_pending,
  output logic       mwr_cyc,
  output logic       mrd_cyc,
  output logic       adr15_lat,
  output logic       wait_err,
  input  logic       err_clr
);

  wr_state_e         r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_ready_q;
  logic              r_mreq_q;
  logic              r_adr15_lat;
  logic              r_mrd_cyc;
  logic              r_wait_err;

  logic w_wr_start;
  logic w_apply_ok;
  logic w_wait_last;
  logic w_abort;

  // A non-refresh memory cycle that is not a read is treated as a write.
  assign w_wr_start  = !mreq_b && rfsh_b && rd_b;
  assign w_apply_ok  = ((r_state == ST_IDLE) || (r_state == ST_END)) && mreq_b;
  // The counter holds waits already seen; this wait is the WAIT_MAX-th one.
  assign w_wait_last = (r_wcnt == WCNT_W'(WAIT_MAX - 1));
  assign w_abort     = (r_state == ST_T1) && !r_ready_q && w_wait_last;

  ramexp_cfg_reg #(
    .CFG_RESET(cfg_t'(CFG_RESET))
  ) u_cfg_reg (
    .clk          (clk),
    .reset_b      (reset_b),
    .i_iorq_b     (iorq_b),
    .i_wr_b       (wr_b),
    .i_adr15      (adr15),
    .i_data       (data),
    .i_apply_ok   (w_apply_ok),
    .o_cfg        (cfg),
    .o_cfg_pending(cfg_pending)
  );

  // Write FSM, wait watchdog and sticky error flag.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state    <= ST_IDLE;
      r_wcnt     <= '0;
      r_ready_q  <= 1'b1;
      r_wait_err <= 1'b0;
    end else begin
      r_ready_q <= ready;
      case (r_state)
        ST_IDLE, ST_END: begin
          r_wcnt  <= '0;
          r_state <= w_wr_start ? ST_T1 : ST_IDLE;
        end
        ST_T1: begin
          if (r_ready_q) begin
            r_state <= ST_T2;
            r_wcnt  <= '0;
          end else if (w_wait_last) begin
            r_state <= ST_IDLE;
            r_wcnt  <= '0;
          end else begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
          end
        end
        ST_T2: begin
          r_state <= ST_END;
          r_wcnt  <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wcnt  <= '0;
        end
      endcase
      // Set beats clear so an abort is never lost to a coincident err_clr.
      if (w_abort) begin
        r_wait_err <= 1'b1;
      end else if (err_clr) begin
        r_wait_err <= 1'b0;
      end
    end
  end

  // Per-cycle bus status latches.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_mreq_q    <= 1'b1;
      r_adr15_lat <= 1'b0;
      r_mrd_cyc   <= 1'b0;
    end else begin
      r_mreq_q  <= mreq_b;
      r_mrd_cyc <= !mreq_b && rfsh_b && !rd_b;
      if (!mreq_b && r_mreq_q) begin
        r_adr15_lat <= adr15;
      end
    end
  end

  assign mwr_cyc   = (r_state == ST_T1) || (r_state == ST_T2);
  assign mrd_cyc   = r_mrd_cyc;
  assign adr15_lat = r_adr15_lat;
  assign wait_err  = r_wait_err;

endmodule
